// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: NZCV flag register, ARM condition evaluation,
// write-strobe gating and an IT-style predication block.
module cond_exec_unit #(
  parameter int FLAG_GROUPS = 2,
  parameter int MAX_BLOCK   = 4,
  parameter int CNT_W       = $clog2(MAX_BLOCK + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   valid,
  input  logic                   flush,
  input  logic [3:0]             cond,
  input  logic [3:0]             alu_flags,
  input  logic [FLAG_GROUPS-1:0] flag_w,
  input  logic                   pcs,
  input  logic                   reg_w,
  input  logic                   mem_w,
  input  logic                   no_write,
  input  logic                   it_start,
  input  logic [3:0]             it_cond,
  input  logic [CNT_W-1:0]       it_len,
  input  logic [MAX_BLOCK-1:0]   it_mask,
  output logic                   pc_src,
  output logic                   reg_write,
  output logic                   mem_write,
  output logic                   cond_ex,
  output logic [3:0]             flags,
  output logic                   it_active,
  output logic [CNT_W-1:0]       it_remaining
);

  localparam int GW     = 4 / FLAG_GROUPS;
  localparam int SLOT_W = (MAX_BLOCK > 1) ? $clog2(MAX_BLOCK) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             base;
  logic [MAX_BLOCK-1:0]   mask;
  logic [SLOT_W-1:0]      slot;
  logic [3:0]             flags_q;
  logic [3:0]             eff_cond;
  logic                   go;
  logic                   wr_ok;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = ~z;
      4'd2:    cond_pass = cy;
      4'd3:    cond_pass = ~cy;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = ~n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = ~v;
      4'd8:    cond_pass = cy & ~z;
      4'd9:    cond_pass = ~cy | z;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = ~z & (n == v);
      4'd13:   cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  always_comb begin
    go       = valid & en & ~flush;
    eff_cond = (state == ACTIVE) ? (base ^ {3'b000, mask[slot]}) : cond;
    cond_ex  = cond_pass(eff_cond, flags_q);
    wr_ok    = go & cond_ex & ~it_start;
    reg_write = wr_ok & reg_w;
    mem_write = wr_ok & mem_w & ~no_write;
    pc_src    = wr_ok & pcs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (wr_ok) begin
      for (int unsigned g = 0; g < FLAG_GROUPS; g++) begin
        if (flag_w[g])
          flags_q[g*GW +: GW] <= alu_flags[g*GW +: GW];
      end
    end
  end

  // Priority: flush > IT start (restarts even when active) > slot consume/branch exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      base  <= '0;
      mask  <= '0;
      slot  <= '0;
    end else if (en) begin
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (valid && it_start) begin
        if (it_len != '0) begin
          state <= ACTIVE;
          cnt   <= it_len;
          base  <= it_cond;
          mask  <= it_mask;
          slot  <= '0;
        end
      end else if (valid && state == ACTIVE) begin
        if (pc_src) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt  <= cnt - 1'b1;
          slot <= slot + 1'b1;
          if (cnt == CNT_W'(1))
            state <= IDLE;
        end
      end
    end
  end

  assign flags        = flags_q;
  assign it_active    = (state == ACTIVE);
  assign it_remaining = cnt;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Bench for cond_exec_unit: directed vector table followed by random
// stimulus checked against a behavioural model.
module tb_cond_exec_unit;

  localparam int FG = 2;
  localparam int MB = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, valid, flush, pcs, reg_w, mem_w, no_write, it_start;
  logic [3:0]    cond, alu_flags, it_cond;
  logic [FG-1:0] flag_w;
  logic [CW-1:0] it_len;
  logic [MB-1:0] it_mask;
  logic          pc_src, reg_write, mem_write, cond_ex, it_active;
  logic [3:0]    flags;
  logic [CW-1:0] it_remaining;

  cond_exec_unit #(.FLAG_GROUPS(FG), .MAX_BLOCK(MB)) dut (
    .clk(clk), .reset(reset), .en(en), .valid(valid), .flush(flush),
    .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .pcs(pcs),
    .reg_w(reg_w), .mem_w(mem_w), .no_write(no_write), .it_start(it_start),
    .it_cond(it_cond), .it_len(it_len), .it_mask(it_mask), .pc_src(pc_src),
    .reg_write(reg_write), .mem_write(mem_write), .cond_ex(cond_ex),
    .flags(flags), .it_active(it_active), .it_remaining(it_remaining)
  );

  typedef struct {
    logic rst, en, v, fl;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic pcs, rw, mw, nw, its;
    logic [3:0] itc;
    logic [2:0] itl;
    logic [3:0] itm;
    logic chk;
    logic e_pc, e_rw, e_mw, e_cx;
    logic [3:0] e_fl;
    logic e_act;
    logic [2:0] e_rem;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  function automatic vec_t row(
    input logic rst, en_, v, fl, input logic [3:0] c, alu, input logic [1:0] fw,
    input logic p, rw, mw, nw, its, input logic [3:0] itc, input logic [2:0] itl,
    input logic [3:0] itm, input logic chk, input logic epc, erw, emw, ecx,
    input logic [3:0] efl, input logic eact, input logic [2:0] erem);
    vec_t r;
    r = '{rst, en_, v, fl, c, alu, fw, p, rw, mw, nw, its, itc, itl, itm,
          chk, epc, erw, emw, ecx, efl, eact, erem};
    return r;
  endfunction

  task automatic drive(input vec_t r);
    reset = r.rst; en = r.en; valid = r.v; flush = r.fl; cond = r.cond;
    alu_flags = r.alu; flag_w = r.fw; pcs = r.pcs; reg_w = r.rw; mem_w = r.mw;
    no_write = r.nw; it_start = r.its; it_cond = r.itc; it_len = r.itl;
    it_mask = r.itm;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t r);
    chk("pc_src",       idx, int'(pc_src),       int'(r.e_pc));
    chk("reg_write",    idx, int'(reg_write),    int'(r.e_rw));
    chk("mem_write",    idx, int'(mem_write),    int'(r.e_mw));
    chk("cond_ex",      idx, int'(cond_ex),      int'(r.e_cx));
    chk("flags",        idx, int'(flags),        int'(r.e_fl));
    chk("it_active",    idx, int'(it_active),    int'(r.e_act));
    chk("it_remaining", idx, int'(it_remaining), int'(r.e_rem));
  endtask

  // Reference model: plain condition semantics on NZCV integers.
  int m_flags, m_cnt, m_base, m_mask, m_slot;

  function automatic bit passes(input int c, input int f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && n == v;
      13: return z || n != v;
      default: return 1;
    endcase
  endfunction

  initial begin
    vec_t r;
    // row(rst,en,v,fl, cond,alu,fw, pcs,rw,mw,nw, its,itc,itl,itm, chk, pc,rw,mw,cx, flags,act,rem)
    tbl.push_back(row(1,1,0,0, 14,0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0));
    tbl.push_back(row(0,1,1,0,  0,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 0,0,0));
    tbl.push_back(row(0,1,1,0,  1,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 0,0,0));
    tbl.push_back(row(0,1,1,0, 14,4,2, 0,0,0,0, 0,0,0,0, 1, 0,0,0,1, 0,0,0));
    tbl.push_back(row(0,1,1,0,  0,0,0, 0,0,1,0, 0,0,0,0, 1, 0,0,1,1, 4,0,0));
    tbl.push_back(row(0,1,1,0,  0,0,0, 0,0,1,1, 0,0,0,0, 1, 0,0,0,1, 4,0,0));
    tbl.push_back(row(0,1,1,0, 14,11,1,0,0,0,0, 0,0,0,0, 1, 0,0,0,1, 4,0,0));
    tbl.push_back(row(0,1,1,0,  2,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,0,0));
    tbl.push_back(row(0,1,1,0,  8,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 7,0,0));
    // IT EQ len 3 mask 010, Z=1
    tbl.push_back(row(0,1,1,0, 14,0,0, 1,1,0,0, 1,0,3,2, 1, 0,0,0,1, 7,0,0));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,1,3));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 7,1,2));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,1,1));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,0,0));
    // len 4 with stalls and a bubble
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,0,0,0, 1,0,4,0, 1, 0,0,0,1, 7,0,0));
    tbl.push_back(row(0,0,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,1, 7,1,4));
    tbl.push_back(row(0,0,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,1, 7,1,4));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,1,4));
    tbl.push_back(row(0,1,0,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,1, 7,1,3));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,1,3));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,1,2));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 7,1,1));
    tbl.push_back(row(0,1,1,0,  1,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 7,0,0));
    // taken branch ends block
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,0,0,0, 1,0,3,0, 1, 0,0,0,1, 7,0,0));
    tbl.push_back(row(0,1,1,0, 14,0,0, 1,0,0,0, 0,0,0,0, 1, 1,0,0,1, 7,1,3));
    tbl.push_back(row(0,1,1,0,  1,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 7,0,0));
    // flush with it_start, flush mid-block
    tbl.push_back(row(0,1,1,1, 14,0,0, 0,1,0,0, 1,0,3,0, 1, 0,0,0,1, 7,0,0));
    tbl.push_back(row(0,1,1,0,  1,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 7,0,0));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,0,0,0, 1,0,3,0, 1, 0,0,0,1, 7,0,0));
    tbl.push_back(row(0,1,1,1, 14,0,3, 0,1,0,0, 0,0,0,0, 1, 0,0,0,1, 7,1,3));
    tbl.push_back(row(0,1,1,0,  1,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 7,0,0));
    // reset mid-block
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,0,0,0, 1,0,3,0, 1, 0,0,0,1, 7,0,0));
    tbl.push_back(row(1,1,0,0, 14,0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0));
    tbl.push_back(row(0,1,1,0,  1,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 0,0,0));
    // predicated flag update visible to the next slot
    tbl.push_back(row(0,1,1,0, 14,4,2, 0,0,0,0, 0,0,0,0, 1, 0,0,0,1, 0,0,0));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,0,0,0, 1,0,2,0, 1, 0,0,0,1, 4,0,0));
    tbl.push_back(row(0,1,1,0, 14,0,2, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 4,1,2));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,0,0,0, 0,1,1));
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 0,0,0));
    // it_len = 0 is ignored
    tbl.push_back(row(0,1,1,0, 14,0,0, 0,0,0,0, 1,0,0,0, 1, 0,0,0,1, 0,0,0));
    tbl.push_back(row(0,1,1,0,  1,0,0, 0,1,0,0, 0,0,0,0, 1, 0,1,0,1, 0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk) check_all(i, tbl[i]);
    end

    // Random phase: start from reset so the model and DUT agree.
    @(negedge clk);
    drive(row(1,1,0,0, 14,0,0, 0,0,0,0, 0,0,0,0, 0, 0,0,0,0, 0,0,0));
    m_flags = 0; m_cnt = 0; m_base = 0; m_mask = 0; m_slot = 0;

    for (int i = 0; i < 3000; i++) begin
      int ec;
      bit cx, go, wr;
      @(negedge clk);
      r.rst  = ($urandom_range(0, 99) == 0);
      r.en   = ($urandom_range(0, 7) != 0);
      r.v    = ($urandom_range(0, 7) != 0);
      r.fl   = ($urandom_range(0, 19) == 0);
      r.cond = 4'($urandom);
      r.alu  = 4'($urandom);
      r.fw   = 2'($urandom);
      r.pcs  = ($urandom_range(0, 5) == 0);
      r.rw   = 1'($urandom);
      r.mw   = 1'($urandom);
      r.nw   = 1'($urandom);
      r.its  = ($urandom_range(0, 7) == 0);
      r.itc  = 4'($urandom);
      r.itl  = 3'($urandom_range(0, MB));
      r.itm  = 4'($urandom);
      r.chk  = 1'b1;

      ec = (m_cnt > 0) ? (m_base ^ ((m_mask >> m_slot) & 1)) : int'(r.cond);
      cx = passes(ec, m_flags);
      go = r.v && r.en && !r.fl;
      wr = go && cx && !r.its;
      r.e_pc  = wr && r.pcs;
      r.e_rw  = wr && r.rw;
      r.e_mw  = wr && r.mw && !r.nw;
      r.e_cx  = cx;
      r.e_fl  = 4'(m_flags);
      r.e_act = (m_cnt != 0);
      r.e_rem = 3'(m_cnt);

      drive(r);
      #1;
      check_all(1000 + i, r);

      if (r.rst) begin
        m_flags = 0; m_cnt = 0; m_base = 0; m_mask = 0; m_slot = 0;
      end else if (r.en) begin
        if (wr) begin
          if (r.fw[1]) m_flags = (m_flags & 'h3) | (int'(r.alu) & 'hC);
          if (r.fw[0]) m_flags = (m_flags & 'hC) | (int'(r.alu) & 'h3);
        end
        if (r.fl) m_cnt = 0;
        else if (r.v && r.its) begin
          if (r.itl != 0) begin
            m_cnt = r.itl; m_base = r.itc; m_mask = r.itm; m_slot = 0;
          end
        end else if (r.v && m_cnt > 0) begin
          if (wr && r.pcs) m_cnt = 0;
          else begin m_cnt--; m_slot++; end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
